// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control for load-use, multi-cycle multiply and MEM-resolved branches
module hazard_ctrl #(
  parameter int MULT_LAT = 2
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        enable,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_is_mult,
  input  logic        mem_pc_src,
  input  logic        mem_jump,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mult_start,
  output logic        mult_abort,
  output logic        mult_busy,
  output logic [31:0] stall_cnt
);
  typedef enum logic {S_RUN, S_WAIT} state_t;
  localparam logic MULTI = MULT_LAT > 1;
  localparam logic [3:0] CNT_INIT = MULTI ? 4'(MULT_LAT - 2) : 4'd0;
  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic go, flush, load_use, mstall, lstall;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= S_RUN;
      cnt       <= '0;
      stall_cnt <= '0;
    end else if (enable) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
  end
  always_comb begin
    state_nxt = flush ? S_RUN : state == S_RUN ? (ex_is_mult && MULTI ? S_WAIT : S_RUN) : (cnt != 4'd0 ? S_WAIT : S_RUN);
    cnt_nxt   = flush ? 4'd0 : state == S_RUN ? (ex_is_mult && MULTI ? CNT_INIT : 4'd0) : (cnt != 4'd0 ? cnt - 4'd1 : 4'd0);
  end
  always_comb begin
    go           = arst_n & enable;
    flush        = go & (mem_pc_src | mem_jump);
    load_use     = ex_mem_read & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
    mstall       = go & ~flush & ((state == S_RUN & ex_is_mult & MULTI) | (state == S_WAIT & cnt != 4'd0));
    lstall       = go & ~flush & state == S_RUN & ~ex_is_mult & load_use;
    pc_en        = go & ~mstall & ~lstall;
    if_id_en     = go & ~mstall & ~lstall;
    id_ex_en     = go & ~mstall;
    ex_mem_en    = go;
    mem_wb_en    = go;
    if_id_flush  = flush;
    id_ex_flush  = flush | lstall;
    ex_mem_flush = flush | mstall;
    mult_start   = go & ~flush & state == S_RUN & ex_is_mult;
    mult_abort   = flush & state == S_WAIT;
    mult_busy    = arst_n & state == S_WAIT;
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against a cycle-level reference model
module tb_hazard_ctrl;
  localparam int L = 3;
  logic clk = 0, arst_n = 0, enable = 0, id_uses_rs2 = 0, ex_mem_read = 0, ex_is_mult = 0, mem_pc_src = 0, mem_jump = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush;
  logic mult_start, mult_abort, mult_busy;
  logic [31:0] stall_cnt;
  int checks = 0, errors = 0, m_left = 0;
  longint sc = 0;
  always #5 clk = ~clk;
  hazard_ctrl #(.MULT_LAT(L)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_mult(ex_is_mult),
    .mem_pc_src(mem_pc_src), .mem_jump(mem_jump), .pc_en(pc_en), .if_id_en(if_id_en),
    .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .mult_start(mult_start),
    .mult_abort(mult_abort), .mult_busy(mult_busy), .stall_cnt(stall_cnt)
  );
  task automatic drive(input logic en, input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic mr, input logic mul, input logic pcs, input logic jmp);
    enable = en; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2; ex_rd = rd;
    ex_mem_read = mr; ex_is_mult = mul; mem_pc_src = pcs; mem_jump = jmp;
  endtask
  // m_left = WAIT cycles still owed by an in-flight multiply (0 = none)
  task automatic step(input string tag);
    logic [10:0] e, a;
    logic fl, lu, busy;
    @(negedge clk);
    if (!arst_n) begin m_left = 0; sc = 0; end
    fl = mem_pc_src | mem_jump;
    lu = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
    busy = m_left > 0;
    if (!arst_n) e = '0;
    else if (!enable) e = {10'b0, busy};
    else if (fl) e = {8'b11111_111, 1'b0, busy, busy};
    else if (busy) e = m_left > 1 ? 11'b00011_001_00_1 : 11'b11111_000_00_1;
    else if (ex_is_mult) e = L > 1 ? 11'b00011_001_10_0 : 11'b11111_000_10_0;
    else if (lu) e = 11'b00111_010_00_0;
    else e = 11'b11111_000_00_0;
    a = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush, mult_start, mult_abort, mult_busy};
    checks++;
    assert (a === e) else begin errors++; $error("FAIL %s outputs got %b want %b", tag, a, e); end
    checks++;
    assert (stall_cnt === 32'(sc)) else begin errors++; $error("FAIL %s stall_cnt got %0d want %0d", tag, stall_cnt, sc); end
    @(posedge clk);
    if (arst_n && enable) begin
      if (!e[10] && sc < 64'hFFFF_FFFF) sc++;
      m_left = fl ? 0 : busy ? m_left - 1 : (ex_is_mult && L > 1) ? L - 1 : 0;
    end
    #1;
  endtask
  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step("reset");
    @(posedge clk); #1; arst_n = 1;
    drive(1, 1, 2, 1, 3, 0, 0, 0, 0); step("normal");
    drive(1, 5, 0, 0, 5, 1, 0, 0, 0); step("load_use");
    drive(1, 5, 0, 0, 6, 0, 0, 0, 0); step("after_load_use");
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0); step("load_x0");
    drive(1, 1, 7, 1, 7, 1, 0, 0, 0); step("load_use_rs2");
    drive(1, 1, 7, 0, 7, 1, 0, 0, 0); step("rs2_unused");
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0); step("mult_start"); step("mult_wait"); step("mult_done");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step("after_mult");
    drive(1, 0, 0, 0, 0, 0, 1, 0, 1); step("flush_wins");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step("post_flush");
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0); step("m2_start");
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0); repeat (3) step("m2_frozen");
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0); step("m2_wait"); step("m2_done");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step("m2_after");
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0); step("ab_start");
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0); step("abort");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step("ab_after");
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0); step("r_start");
    arst_n = 0; step("r_reset");
    arst_n = 1; drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step("r_after");
    repeat (400) begin
      arst_n = $urandom_range(0, 40) != 0;
      drive(1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0));
      step("random");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
